// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and fixed-point helpers for the FFT datapath.
package fft_pkg;

    localparam int BF_LAT = 3;

    typedef logic signed [63:0] wide_t;

    function automatic wide_t sat_to_n(input wide_t x, input int n);
        wide_t hi, lo;
        hi = (wide_t'(1) <<< (n - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

    // Round half toward +inf, then drop q fractional bits.
    function automatic wide_t round_shift(input wide_t x, input int q);
        return (x + (wide_t'(1) <<< (q - 1))) >>> q;
    endfunction

endpackage

// File: rtl/cmul_pipe.sv
// cmul_pipe: two-stage complex multiply B*W (or B*conj(W)) with rounding back to
// the sample scale; stage 1 registers operands, stage 2 registers the rounded product.
module cmul_pipe
    import fft_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic signed [N-1:0] i_b_re,
    input  logic signed [N-1:0] i_b_im,
    input  logic signed [N-1:0] i_w_re,
    input  logic signed [N-1:0] i_w_im,
    input  logic                i_inverse,
    output logic signed [N+1:0] o_p_re,
    output logic signed [N+1:0] o_p_im
);

    typedef logic signed [2*N+1:0] prod_t;
    typedef logic signed [N+1:0]   p_t;

    logic signed [N-1:0] br_q, bi_q, wr_q;
    logic signed [N:0]   wi_x, wi_d, wi_q;
    prod_t               pr, pi;
    p_t                  p_re_d, p_im_d, p_re_q, p_im_q;

    // One extra bit so that conjugating -2^(N-1) yields +2^(N-1).
    always_comb begin
        wi_x   = {i_w_im[N-1], i_w_im};
        wi_d   = i_inverse ? -wi_x : wi_x;
        pr     = prod_t'(br_q) * prod_t'(wr_q) - prod_t'(bi_q) * prod_t'(wi_q);
        pi     = prod_t'(br_q) * prod_t'(wi_q) + prod_t'(bi_q) * prod_t'(wr_q);
        p_re_d = p_t'(round_shift(wide_t'(pr), Q));
        p_im_d = p_t'(round_shift(wide_t'(pi), Q));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            br_q   <= '0;
            bi_q   <= '0;
            wr_q   <= '0;
            wi_q   <= '0;
            p_re_q <= '0;
            p_im_q <= '0;
        end else if (i_en) begin
            br_q   <= i_b_re;
            bi_q   <= i_b_im;
            wr_q   <= i_w_re;
            wi_q   <= wi_d;
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
        end
    end

    assign o_p_re = p_re_q;
    assign o_p_im = p_im_q;

endmodule

// File: rtl/butterfly2_pipe.sv
// butterfly2_pipe: fully pipelined radix-2 DIT butterfly (A +/- B*W) with valid/ready
// handshake, optional /2 scaling, saturation and overflow reporting; latency 3.
module butterfly2_pipe
    import fft_pkg::*;
#(
    parameter int N   = 16,
    parameter int Q   = 8,
    parameter int LAT = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic signed [N-1:0] i_in0_re,
    input  logic signed [N-1:0] i_in0_im,
    input  logic signed [N-1:0] i_in1_re,
    input  logic signed [N-1:0] i_in1_im,
    input  logic signed [N-1:0] i_twiddle_re,
    input  logic signed [N-1:0] i_twiddle_im,
    input  logic                i_inverse,
    input  logic                i_scale,
    input  logic                i_clr_ovf,
    output logic                o_valid,
    input  logic                i_ready,
    output logic signed [N-1:0] o_out0_re,
    output logic signed [N-1:0] o_out0_im,
    output logic signed [N-1:0] o_out1_re,
    output logic signed [N-1:0] o_out1_im,
    output logic                o_ovf,
    output logic                o_ovf_sticky
);

    typedef logic signed [N+2:0] sum_t;

    if (LAT != BF_LAT || Q < 1 || Q > N - 2) begin : g_param_chk
        $error("butterfly2_pipe: requires LAT == 3 and 1 <= Q <= N-2");
    end

    logic                en;
    logic                v1_q, v2_q, v3_q;
    logic signed [N-1:0] a1_re_q, a1_im_q, a2_re_q, a2_im_q;
    logic                sc1_q, sc2_q;
    logic signed [N+1:0] p_re, p_im;
    logic signed [N-1:0] o0r_d, o0i_d, o1r_d, o1i_d, o0r_q, o0i_q, o1r_q, o1i_q;
    logic [3:0]          sat_hit;
    logic                ovf_d, ovf_q, sticky_d, sticky_q;

    // Returns {saturated, value}; optional halving rounds half up before clamping.
    function automatic logic [N:0] scale_sat(input sum_t s, input logic sc);
        sum_t  t;
        wide_t w;
        t = sc ? (s + sum_t'(1)) >>> 1 : s;
        w = sat_to_n(wide_t'(t), N);
        return {w != wide_t'(t), w[N-1:0]};
    endfunction

    assign en      = ~v3_q | i_ready;
    assign o_ready = en;

    cmul_pipe #(.N(N), .Q(Q)) u_cmul (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (en),
        .i_b_re    (i_in1_re),
        .i_b_im    (i_in1_im),
        .i_w_re    (i_twiddle_re),
        .i_w_im    (i_twiddle_im),
        .i_inverse (i_inverse),
        .o_p_re    (p_re),
        .o_p_im    (p_im)
    );

    always_comb begin
        {sat_hit[0], o0r_d} = scale_sat(sum_t'(a2_re_q) + sum_t'(p_re), sc2_q);
        {sat_hit[1], o0i_d} = scale_sat(sum_t'(a2_im_q) + sum_t'(p_im), sc2_q);
        {sat_hit[2], o1r_d} = scale_sat(sum_t'(a2_re_q) - sum_t'(p_re), sc2_q);
        {sat_hit[3], o1i_d} = scale_sat(sum_t'(a2_im_q) - sum_t'(p_im), sc2_q);
        ovf_d    = |sat_hit;
        sticky_d = (v3_q & i_ready & ovf_q) | (sticky_q & ~i_clr_ovf);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            a1_re_q  <= '0;
            a1_im_q  <= '0;
            a2_re_q  <= '0;
            a2_im_q  <= '0;
            sc1_q    <= 1'b0;
            sc2_q    <= 1'b0;
            o0r_q    <= '0;
            o0i_q    <= '0;
            o1r_q    <= '0;
            o1i_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            if (en) begin
                v1_q    <= i_valid;
                a1_re_q <= i_in0_re;
                a1_im_q <= i_in0_im;
                sc1_q   <= i_scale;
                v2_q    <= v1_q;
                a2_re_q <= a1_re_q;
                a2_im_q <= a1_im_q;
                sc2_q   <= sc1_q;
                v3_q    <= v2_q;
                o0r_q   <= o0r_d;
                o0i_q   <= o0i_d;
                o1r_q   <= o1r_d;
                o1i_q   <= o1i_d;
                ovf_q   <= ovf_d;
            end
        end
    end

    assign o_valid      = v3_q;
    assign o_out0_re    = o0r_q;
    assign o_out0_im    = o0i_q;
    assign o_out1_re    = o1r_q;
    assign o_out1_im    = o1i_q;
    assign o_ovf        = ovf_q;
    assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_butterfly2_pipe.sv
// tb_butterfly2_pipe: directed and randomized stimulus against a scoreboard of
// butterfly results computed with plain integer arithmetic.
module tb_butterfly2_pipe;

    localparam int N = 16;
    localparam int Q = 8;

    typedef struct {
        longint ar, ai, br, bi, wr, wi;
        bit     inv, sc;
    } in_t;

    typedef struct {
        longint o0r, o0i, o1r, o1i;
        bit     ovf;
        longint t;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_valid, o_ready, i_inverse, i_scale, i_clr_ovf;
    logic                o_valid, i_ready, o_ovf, o_ovf_sticky;
    logic signed [N-1:0] i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_tw_re, i_tw_im;
    logic signed [N-1:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;

    exp_t   q[$];
    exp_t   none;
    in_t    idle;
    longint en_cnt = 0;
    bit     sticky = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;

    butterfly2_pipe #(.N(N), .Q(Q), .LAT(3)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_in0_re     (i_in0_re),
        .i_in0_im     (i_in0_im),
        .i_in1_re     (i_in1_re),
        .i_in1_im     (i_in1_im),
        .i_twiddle_re (i_tw_re),
        .i_twiddle_im (i_tw_im),
        .i_inverse    (i_inverse),
        .i_scale      (i_scale),
        .i_clr_ovf    (i_clr_ovf),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_out0_re    (o_out0_re),
        .o_out0_im    (o_out0_im),
        .o_out1_re    (o_out1_re),
        .o_out1_im    (o_out1_im),
        .o_ovf        (o_ovf),
        .o_ovf_sticky (o_ovf_sticky)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Butterfly from its definition: A +/- round(B*W / 2^Q), optional /2, clamp.
    function automatic exp_t model(input in_t x);
        exp_t   e;
        longint wi, pr, pi, hi, lo, half;
        longint s[4];
        wi   = x.inv ? -x.wi : x.wi;
        half = longint'(1) << (Q - 1);
        pr   = (x.br * x.wr - x.bi * wi + half) >>> Q;
        pi   = (x.br * wi + x.bi * x.wr + half) >>> Q;
        s[0] = x.ar + pr;
        s[1] = x.ai + pi;
        s[2] = x.ar - pr;
        s[3] = x.ai - pi;
        hi   = (longint'(1) << (N - 1)) - 1;
        lo   = -hi - 1;
        e.ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (x.sc) s[k] = (s[k] + 1) >>> 1;
            if (s[k] > hi) begin
                s[k] = hi;
                e.ovf = 1'b1;
            end else if (s[k] < lo) begin
                s[k] = lo;
                e.ovf = 1'b1;
            end
        end
        e.o0r = s[0];
        e.o0i = s[1];
        e.o1r = s[2];
        e.o1i = s[3];
        e.t   = 0;
        return e;
    endfunction

    function automatic in_t mk(input longint ar, ai, br, bi, wr, wi, input bit inv, sc);
        in_t x;
        x.ar = ar; x.ai = ai; x.br = br; x.bi = bi; x.wr = wr; x.wi = wi;
        x.inv = inv; x.sc = sc;
        return x;
    endfunction

    function automatic exp_t ex(input longint o0r, o0i, o1r, o1i, input bit ovf);
        exp_t e;
        e.o0r = o0r; e.o0i = o0i; e.o1r = o1r; e.o1i = o1i; e.ovf = ovf; e.t = 0;
        return e;
    endfunction

    function automatic longint rsamp();
        int unsigned         u;
        logic signed [N-1:0] r;
        u = $urandom_range(0, 7);
        r = N'($urandom);
        return (u == 0) ? -(longint'(1) << (N - 1)) :
               (u == 1) ? (longint'(1) << (N - 1)) - 1 : longint'(r);
    endfunction

    // Twiddle components stay within +/-1.0 so the product fits its rounded width.
    function automatic longint rtw();
        return longint'($urandom_range(0, 2 << Q)) - (longint'(1) << Q);
    endfunction

    // One clock: drive, settle, check against scoreboard, update model, advance.
    task automatic cyc(input in_t x, input bit v, input bit rdy, input bit clr,
                       input bit dir, input exp_t de, output bit acc);
        bit   ev, en;
        exp_t e;
        i_valid   = v;
        i_in0_re  = N'(x.ar);
        i_in0_im  = N'(x.ai);
        i_in1_re  = N'(x.br);
        i_in1_im  = N'(x.bi);
        i_tw_re   = N'(x.wr);
        i_tw_im   = N'(x.wi);
        i_inverse = x.inv;
        i_scale   = x.sc;
        i_ready   = rdy;
        i_clr_ovf = clr;
        #1;
        ev = q.size() > 0 && (en_cnt - q[0].t) == 3;
        en = !ev || rdy;
        chk("o_valid", o_valid, ev);
        chk("o_ready", o_ready, en);
        chk("o_ovf_sticky", o_ovf_sticky, sticky);
        if (ev) begin
            chk("out0_re", o_out0_re, q[0].o0r);
            chk("out0_im", o_out0_im, q[0].o0i);
            chk("out1_re", o_out1_re, q[0].o1r);
            chk("out1_im", o_out1_im, q[0].o1i);
            chk("o_ovf", o_ovf, q[0].ovf);
        end
        acc = v && en;
        if (ev && rdy && q[0].ovf) sticky = 1'b1;
        else if (clr) sticky = 1'b0;
        if (ev && rdy) void'(q.pop_front());
        if (acc) begin
            e   = dir ? de : model(x);
            e.t = en_cnt;
            q.push_back(e);
        end
        if (en) en_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input in_t x, input bit dir, input exp_t e);
        bit acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) cyc(x, 1'b1, 1'b1, 1'b0, dir, e, acc);
        chk("accepted", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int c = 0; c < 20 && q.size() > 0; c++) cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0, none, acc);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_out0_re"}, o_out0_re, 0);
        chk({tag, "_out0_im"}, o_out0_im, 0);
        chk({tag, "_out1_re"}, o_out1_re, 0);
        chk({tag, "_out1_im"}, o_out1_im, 0);
        chk({tag, "_ovf"}, o_ovf, 0);
        chk({tag, "_sticky"}, o_ovf_sticky, 0);
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        q.delete();
        sticky = 1'b0;
        check_idle("reset");
    endtask

    initial begin
        bit  acc;
        int  k;
        in_t x;
        none = ex(0, 0, 0, 0, 0);
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_clr_ovf = 1'b0;
        i_inverse = 1'b0; i_scale = 1'b0;
        i_in0_re = '0; i_in0_im = '0; i_in1_re = '0; i_in1_im = '0; i_tw_re = '0; i_tw_im = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("por");

        put(mk(0, 0, 256, 0, 256, 0, 0, 0), 1, ex(256, 0, -256, 0, 0));
        put(mk(0, 0, 256, 0, 0, -256, 0, 0), 1, ex(0, -256, 0, 256, 0));
        put(mk(0, 0, 256, 0, 0, -256, 1, 0), 1, ex(0, 256, 0, -256, 0));
        put(mk(32767, 0, 256, 0, 256, 0, 0, 0), 1, ex(32767, 0, 32511, 0, 1));
        put(mk(32767, 0, 256, 0, 256, 0, 0, 1), 1, ex(16512, 0, 16256, 0, 0));
        put(mk(10, 0, 1, 0, 128, 0, 0, 0), 1, ex(11, 0, 9, 0, 0));
        put(mk(10, 0, -1, 0, 128, 0, 0, 0), 1, ex(10, 0, 10, 0, 0));
        put(mk(0, 0, 0, 1, 0, -32768, 1, 0), 1, ex(-128, 0, 128, 0, 0));
        put(mk(-32768, 0, 256, 0, 256, 0, 0, 0), 1, ex(-32512, 0, -32768, 0, 1));
        drain();
        repeat (2) cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0, none, acc);
        cyc(idle, 1'b0, 1'b1, 1'b1, 1'b0, none, acc);
        cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0, none, acc);

        k = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            x = mk(rsamp(), rsamp(), rsamp(), rsamp(), rtw(), rtw(), 1'($urandom), 1'($urandom));
            cyc(x, 1'b1, !(c >= 3 && c < 7), 1'b0, 1'b0, none, acc);
            if (acc) k++;
        end
        chk("stall_beats", k, 5);
        drain();

        put(mk(32767, 0, 256, 0, 256, 0, 0, 0), 0, none);
        put(mk(1, 2, 3, 4, 5, 6, 0, 0), 0, none);
        put(mk(7, 8, 9, 10, 11, 12, 1, 0), 0, none);
        cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0, none, acc);
        do_reset();
        put(mk(100, -100, 256, 256, 256, -256, 0, 0), 0, none);
        drain();

        for (int c = 0; c < 800; c++) begin
            x = mk(rsamp(), rsamp(), rsamp(), rsamp(), rtw(), rtw(), 1'($urandom), 1'($urandom));
            cyc(x, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, 1'b0, none, acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/butterfly2_pipe.md
Name: butterfly2_pipe

Overview:
Fully pipelined radix-2 DIT butterfly with a valid/ready stream interface. It replaces the clock-divided, time-multiplexed butterfly: one complex butterfly is accepted per i_clk cycle, using four parallel real multipliers. It adds convergent-free round-half-up, saturation, an optional per-sample divide-by-2 scaling mode, an inverse (conjugate-twiddle) mode and overflow reporting. It sits between the stage address generator / twiddle ROM and the stage result RAM of the FFT core.

Parameters:
N, 16, signed two's-complement sample and twiddle width
Q, 8, fractional bits of the twiddle (1.0 = 2^Q); 1 <= Q <= N-2
LAT, 3, fixed pipeline latency in cycles; only 3 is supported, and the block asserts at elaboration otherwise

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  input beat valid
o_ready  out  1  block can accept a beat this cycle
i_in0_re, i_in0_im  in  N each  operand A
i_in1_re, i_in1_im  in  N each  operand B
i_twiddle_re, i_twiddle_im  in  N each  W^nk, Q fractional bits
i_inverse  in  1  use conj(W); captured with the beat
i_scale  in  1  divide both outputs by 2; captured with the beat
i_clr_ovf  in  1  clear the sticky overflow flag
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts the beat
o_out0_re, o_out0_im  out  N each  A + B*W
o_out1_re, o_out1_im  out  N each  A - B*W
o_ovf  out  1  saturation occurred on the current output beat (any of the 4 outputs)
o_ovf_sticky  out  1  OR of o_ovf over all accepted beats since reset or clear

Behaviour:
- Clock i_clk; reset i_rst is synchronous and active-high. No other clocks and no clock dividers are used.
- Reset values: all stage valid bits = 0, o_valid = 0, all data outputs = 0, o_ovf = 0, o_ovf_sticky = 0. Reset mid-operation discards every in-flight beat; o_valid = 0 on the cycle after i_rst is sampled high.
- Pipeline enable: en = ~o_valid | i_ready. When en = 1, all three stages advance together; when en = 0, every stage holds. o_ready = en (combinational). There is no bubble collapsing.
- A beat is accepted when i_valid & o_ready. It appears on the outputs exactly 3 enabled cycles later. Output data and flags are held stable while o_valid & ~i_ready.
- S1: register A, B, W, inverse and scale. If inverse = 1, take Wi = -Wi, using N+1-bit negation so that -(-2^(N-1)) is handled.
- S2: form the four signed products Br*Wr, Bi*Wi, Br*Wi, Bi*Wr (each 2N+1 bits). Then:
  - Pr = Br*Wr - Bi*Wi
  - Pi = Br*Wi + Bi*Wr
  - Round: add 2^(Q-1), then arithmetic shift right by Q. The result is kept at N+2 bits with no truncation.
- S3: sum0 = A + P and sum1 = A - P, at N+3 bits. If scale = 1, sum = (sum + 1) >>> 1. Saturate to [-2^(N-1), 2^(N-1)-1]. o_ovf is registered with the data.
- o_ovf_sticky is set on any output beat that is transferred (o_valid & i_ready) with o_ovf = 1. i_clr_ovf clears it. If clear and set coincide in the same cycle, set wins.
- Back-to-back throughput is 1 beat/cycle while i_ready = 1. i_valid = 0 cycles propagate as bubbles.

Decomposition:
- Shared package fft_pkg holds:
  - sat_to_n function (saturate a wide signed value to N bits)
  - round_shift function (add half-LSB, arithmetic shift by Q)
  - localparam BF_LAT = 3
- One sub-module: cmul_pipe, the two-stage complex multiply with conjugate option and rounding (covers S1-S2). The adders, scaling, saturation and handshake stay in the top module.

Test Plan:
All cases use N=16, Q=8 unless stated.
1. A=(0,0), B=(256,0), W=(256,0), i_ready=1 -> 3 cycles later: out0=(256,0), out1=(-256,0), o_ovf=0.
2. A=(0,0), B=(256,0), W=(0,-256):
   - inverse=0 -> out0=(0,-256), out1=(0,256).
   - inverse=1 -> out0=(0,256), out1=(0,-256).
3. A=(32767,0), B=(256,0), W=(256,0):
   - scale=0 -> out0_re=32767 (saturated), out1_re=32511, o_ovf=1, o_ovf_sticky=1 until i_clr_ovf pulses.
   - same beat with scale=1 -> out0_re=16512, out1_re=16256, o_ovf=0.
4. Rounding: A=(10,0), B=(1,0), W=(128,0) -> product rounds 0.5 up to 1: out0_re=11, out1_re=9. With B=(-1,0): out0_re=10, out1_re=10.
5. Back-pressure: stream 5 beats with i_valid=1 and hold i_ready=0 from cycle 3 for 4 cycles -> o_ready=0 while stalled, outputs stable, all 5 beats delivered in order with no loss or duplication.
6. Stream 3 beats, assert i_rst one cycle while 2 are in flight -> o_valid=0 and all outputs=0 next cycle, o_ovf_sticky=0, and a new beat after reset has latency 3.
